// File: rtl/host_mem_cmd_decoder_pkg.sv
// Shared constants for the host byte-stream memory command decoder:
// opcodes, widths and the FSM state encoding.
package host_mem_cmd_decoder_pkg;

    localparam int NB      = 16;
    localparam int NB_ADDR = 23;

    localparam logic [7:0] OP_READ  = 8'h10;
    localparam logic [7:0] OP_WRITE = 8'h20;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_ADDR2      = 4'd1;
    localparam logic [3:0] S_ADDR1      = 4'd2;
    localparam logic [3:0] S_ADDR0      = 4'd3;
    localparam logic [3:0] S_COUNT      = 4'd4;
    localparam logic [3:0] S_WR_COLLECT = 4'd5;
    localparam logic [3:0] S_WR_ISSUE   = 4'd6;
    localparam logic [3:0] S_RD_ISSUE   = 4'd7;
    localparam logic [3:0] S_RD_WAIT    = 4'd8;
    localparam logic [3:0] S_RD_SEND    = 4'd9;

    // Byte-enable bit for a byte landing in lane addr[0].
    function automatic logic [1:0] lane_mask(input logic lane);
        return lane ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/host_mem_cmd_decoder.sv
// Parses opcode/address/count headers from the host byte stream and turns
// them into 16-bit word read/write requests; read bytes go back to the host.
module host_mem_cmd_decoder
    import host_mem_cmd_decoder_pkg::*;
#(
    parameter int Nb_addr = NB_ADDR,
    parameter int Nb      = NB
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         h2f_data,
    input  logic               h2f_valid,
    output logic               h2f_ready,
    output logic [7:0]         f2h_data,
    output logic               f2h_valid,
    input  logic               f2h_ready,
    output logic               mem_cmd_valid,
    input  logic               mem_cmd_ready,
    output logic               mem_cmd_write,
    output logic [Nb_addr-1:0] mem_cmd_addr,
    output logic [Nb-1:0]      mem_cmd_wdata,
    output logic [1:0]         mem_cmd_be,
    input  logic               mem_rd_valid,
    input  logic [Nb-1:0]      mem_rd_data,
    output logic               busy,
    output logic               err_cmd
);

    localparam int AW = Nb_addr + 1;

    logic [3:0]    state;
    logic [AW-1:0] addr;
    logic [7:0]    remaining;
    logic          is_wr;
    logic          rdy_en;
    logic [Nb-1:0] wbuf;
    logic [1:0]    be_acc;
    logic [7:0]    rdata_hi;

    logic          h2f_fire, f2h_fire, lane;
    logic [AW-1:0] addr_nxt;
    logic [7:0]    rem_nxt;
    logic [Nb-1:0] wdata_merged;

    assign lane     = addr[0];
    assign addr_nxt = addr + 1'b1;
    assign rem_nxt  = remaining - 8'd1;
    assign h2f_fire = h2f_valid & h2f_ready;
    assign f2h_fire = f2h_valid & f2h_ready;
    assign busy     = (state != S_IDLE);

    // rdy_en keeps h2f_ready low until the first edge after reset release.
    assign h2f_ready = rdy_en & (state inside {S_IDLE, S_ADDR2, S_ADDR1, S_ADDR0,
                                               S_COUNT, S_WR_COLLECT});

    always_comb begin
        wdata_merged = wbuf;
        if (lane) wdata_merged[15:8] = h2f_data;
        else      wdata_merged[7:0]  = h2f_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            addr          <= '0;
            remaining     <= '0;
            is_wr         <= 1'b0;
            rdy_en        <= 1'b0;
            wbuf          <= '0;
            be_acc        <= '0;
            rdata_hi      <= '0;
            f2h_data      <= '0;
            f2h_valid     <= 1'b0;
            mem_cmd_valid <= 1'b0;
            mem_cmd_write <= 1'b0;
            mem_cmd_addr  <= '0;
            mem_cmd_wdata <= '0;
            mem_cmd_be    <= '0;
            err_cmd       <= 1'b0;
        end else begin
            rdy_en  <= 1'b1;
            err_cmd <= 1'b0;
            case (state)
                S_IDLE: if (h2f_fire) begin
                    if (h2f_data == OP_WRITE || h2f_data == OP_READ) begin
                        is_wr <= (h2f_data == OP_WRITE);
                        state <= S_ADDR2;
                    end else begin
                        err_cmd <= 1'b1;
                    end
                end
                S_ADDR2: if (h2f_fire) begin
                    addr[AW-1:16] <= h2f_data;
                    state         <= S_ADDR1;
                end
                S_ADDR1: if (h2f_fire) begin
                    addr[15:8] <= h2f_data;
                    state      <= S_ADDR0;
                end
                S_ADDR0: if (h2f_fire) begin
                    addr[7:0] <= h2f_data;
                    state     <= S_COUNT;
                end
                S_COUNT: if (h2f_fire) begin
                    remaining <= h2f_data;
                    if (h2f_data == 8'd0) begin
                        state <= S_IDLE;
                    end else if (is_wr) begin
                        wbuf   <= '0;
                        be_acc <= '0;
                        state  <= S_WR_COLLECT;
                    end else begin
                        mem_cmd_valid <= 1'b1;
                        mem_cmd_write <= 1'b0;
                        mem_cmd_addr  <= addr[AW-1:1];
                        mem_cmd_be    <= 2'b11;
                        state         <= S_RD_ISSUE;
                    end
                end
                S_WR_COLLECT: if (h2f_fire) begin
                    addr      <= addr_nxt;
                    remaining <= rem_nxt;
                    // A word is flushed once its high lane fills or the burst ends.
                    if (lane || rem_nxt == 8'd0) begin
                        mem_cmd_valid <= 1'b1;
                        mem_cmd_write <= 1'b1;
                        mem_cmd_addr  <= addr[AW-1:1];
                        mem_cmd_wdata <= wdata_merged;
                        mem_cmd_be    <= be_acc | lane_mask(lane);
                        wbuf          <= '0;
                        be_acc        <= '0;
                        state         <= S_WR_ISSUE;
                    end else begin
                        wbuf   <= wdata_merged;
                        be_acc <= be_acc | lane_mask(lane);
                    end
                end
                S_WR_ISSUE: if (mem_cmd_ready) begin
                    mem_cmd_valid <= 1'b0;
                    state         <= (remaining != 8'd0) ? S_WR_COLLECT : S_IDLE;
                end
                S_RD_ISSUE: if (mem_cmd_ready) begin
                    mem_cmd_valid <= 1'b0;
                    state         <= S_RD_WAIT;
                end
                S_RD_WAIT: if (mem_rd_valid) begin
                    rdata_hi  <= mem_rd_data[15:8];
                    f2h_data  <= lane ? mem_rd_data[15:8] : mem_rd_data[7:0];
                    f2h_valid <= 1'b1;
                    state     <= S_RD_SEND;
                end
                S_RD_SEND: if (f2h_fire) begin
                    addr      <= addr_nxt;
                    remaining <= rem_nxt;
                    if (rem_nxt == 8'd0) begin
                        f2h_valid <= 1'b0;
                        state     <= S_IDLE;
                    end else if (addr_nxt[0]) begin
                        f2h_data <= rdata_hi;
                    end else begin
                        f2h_valid     <= 1'b0;
                        mem_cmd_valid <= 1'b1;
                        mem_cmd_write <= 1'b0;
                        mem_cmd_addr  <= addr_nxt[AW-1:1];
                        mem_cmd_be    <= 2'b11;
                        state         <= S_RD_ISSUE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/host_mem_cmd_decoder.md
# host_mem_cmd_decoder

Device-side responder for the host byte-stream memory protocol carried on the FX2 channel interface. It parses opcode/address/count headers from the host-to-FPGA byte stream and issues 16-bit word read and write requests to the CellRAM controller. For reads, it returns the requested bytes on the FPGA-to-host stream. It sits between the FX2 comm FIFOs and the memory controller inside the demo top level.

## Interface
Parameters:
- Nb_addr, 23, word address width; the host byte address is Nb_addr+1 = 24 bits.
- Nb, 16, memory word width; fixed at 16.

Ports:
- clk  in  1  single clock for host stream and memory request side.
- reset  in  1  reset is synchronous and active-low (asserted at 0).
- h2f_data  in  8  host-to-FPGA byte.
- h2f_valid  in  1  byte present.
- h2f_ready  out  1  byte accepted on clk edge when valid&ready.
- f2h_data  out  8  FPGA-to-host byte.
- f2h_valid  out  1  byte present.
- f2h_ready  in  1  host sink accepts.
- mem_cmd_valid  out  1  request pending.
- mem_cmd_ready  in  1  controller accepts request.
- mem_cmd_write  out  1  1 = write, 0 = read.
- mem_cmd_addr  out  Nb_addr  word address (byte_addr[23:1]).
- mem_cmd_wdata  out  Nb  write word; the byte at the even address is in [7:0], the byte at the odd address is in [15:8].
- mem_cmd_be  out  2  byte enables; bit0 = low lane (lb), bit1 = high lane (ub).
- mem_rd_valid  in  1  one-cycle pulse carrying read data; there is no backpressure.
- mem_rd_data  in  Nb  read word.
- busy  out  1  high whenever the state is not IDLE.
- err_cmd  out  1  one-cycle pulse on an unknown opcode.

## Operation
- Protocol:
  - Write: 0x20, A[23:16], A[15:8], A[7:0], N, then N data bytes.
  - Read: 0x10, A[23:16], A[15:8], A[7:0], N; the device returns N bytes.
  - N is 0..255.
- States:
  - IDLE: accept opcode; 0x20 or 0x10 goes to ADDR2; any other value pulses err_cmd, drops the byte and stays in IDLE.
  - ADDR2 → ADDR1 → ADDR0 → COUNT.
  - COUNT: N=0 goes to IDLE with no memory access. Otherwise go to WR_COLLECT (write) or RD_ISSUE (read).
  - WR_COLLECT: accept bytes into the lane given by the current addr[0]; then increment addr and decrement remaining.
  - Go to WR_ISSUE when either of these holds:
    - the high lane has just been filled;
    - remaining reaches 0.
  - mem_cmd_be equals the lanes filled in the current word:
    - odd start gives 2'b10;
    - trailing byte on an even address gives 2'b01;
    - a full word gives 2'b11.
  - WR_ISSUE: hold the request until mem_cmd_ready. Then go to WR_COLLECT if remaining > 0, else IDLE.
  - RD_ISSUE: read request with be=2'b11, held until ready, then go to RD_WAIT.
  - RD_WAIT: capture mem_rd_data on mem_rd_valid.
  - RD_SEND: emit the byte from lane addr[0]; on the f2h handshake, increment addr and decrement remaining.
    - remaining = 0 → IDLE.
    - Otherwise, if the new addr[0] = 1, stay in RD_SEND for the high lane of the same word.
    - Otherwise go to RD_ISSUE.
- Only one read is outstanding at a time; mem_rd_valid outside RD_WAIT is ignored.
- Address arithmetic is modulo 2^24. Byte 0xFFFFFF wraps to 0x000000, so the word address wraps to 0.

## Timing
- Reset values: h2f_ready=0, f2h_valid=0, f2h_data=0, mem_cmd_valid=0, mem_cmd_write=0, mem_cmd_addr=0, mem_cmd_wdata=0, mem_cmd_be=0, busy=0, err_cmd=0.
- h2f_ready=1 from the first cycle after reset is released in IDLE/ADDRx/COUNT/WR_COLLECT; it is 0 in all other states.
- The request appears the cycle after the COUNT byte (read) or the completing data byte (write) is accepted.
- mem_cmd_* are stable while valid&!ready.
- f2h_valid rises the cycle after mem_rd_valid. f2h_data is stable while valid&!ready.
- Reset mid-command abandons the command with no further requests; a pending mem_cmd_valid drops.

## Structure
- Opcode constants (OP_READ=8'h10, OP_WRITE=8'h20) and the state encoding go in the shared parameters.v include.
- Nb and Nb_addr also come from parameters.v.
- Single module with no sub-module. Output buffering, if needed, uses the existing fifo_sync outside the block.

## Test plan
- Write A=0x000000, N=1, data 0xA5 → one request: addr 0, be=01, wdata[7:0]=A5. Then read it back → f2h returns A5, followed by exactly one read request.
- Write A=0x00A0F2, N=22 → 11 requests, all be=11, addrs 0x5079..0x5083. Readback matches all 22 bytes.
- Write A=0x48A0F5, N=19 → first request be=10 at 0x24507A, then 9 requests with be=11. Readback returns 19 bytes in order.
- Write A=0xFFFFFF, N=3 → requests at word 0x7FFFFF (be=10) then word 0 (be=11); the address wraps.
- Opcode 0x55 → err_cmd pulses for 1 cycle and the state stays IDLE. A subsequent valid read executes normally. A read with N=0 → no request and no f2h byte.
- Hold f2h_ready=0 for 50 cycles mid-read → f2h_data is held and no extra requests are issued. Reset asserted in RD_WAIT → all outputs return to 0 and a late mem_rd_valid is ignored.
